// File: rtl/vec_mem.sv
// Byte-masked word memory with a zeroing sweep after reset and on clear_req.
// Define VEC_MEM_BYPASS_EN to forward write data on a same-address read/write.
module vec_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int MEM_SIZE   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write_en,
  input  logic [ADDR_WIDTH-1:0]   write_address,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    read_en,
  input  logic [ADDR_WIDTH-1:0]   read_address,
  input  logic                    clear_req,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    read_valid,
  output logic                    busy,
  output logic                    addr_err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [IW-1:0] LAST = IW'(MEM_SIZE - 1);

  typedef enum logic [1:0] {
    SWEEP,
    IDLE,
    SWEEP_REQ
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   sw_addr;
  logic [IW-1:0]   sw_addr_nx;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  logic                  idle;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  wr_in;
  logic                  rd_in;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;

  assign idle   = (state == IDLE);
  assign busy   = !idle;
  assign wr_acc = idle && write_en;
  assign rd_acc = idle && read_en;
  assign wr_in  = {1'b0, write_address} < LIM;
  assign rd_in  = {1'b0, read_address} < LIM;
  assign wr_idx = write_address[IW-1:0];
  assign rd_idx = read_address[IW-1:0];

`ifdef VEC_MEM_BYPASS_EN
  logic                  hit;
  logic [DATA_WIDTH-1:0] merged;

  assign hit = wr_acc && wr_in && rd_in &&
               (write_address == read_address);

  always_comb begin
    merged = mem[rd_idx];
    for (int b = 0; b < NB; b++) begin
      if (byte_en[b]) begin
        merged[8*b +: 8] = data_in[8*b +: 8];
      end
    end
    rd_data = hit ? merged : mem[rd_idx];
  end
`else
  // Nonblocking array update means this sees the pre-write word.
  always_comb begin
    rd_data = mem[rd_idx];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SWEEP;
      sw_addr <= '0;
    end else begin
      state   <= state_nx;
      sw_addr <= sw_addr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    sw_addr_nx = sw_addr;
    unique case (state)
      SWEEP, SWEEP_REQ: begin
        sw_addr_nx = sw_addr + 1'b1;
        if (sw_addr == LAST) begin
          state_nx   = IDLE;
          sw_addr_nx = '0;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_nx = SWEEP_REQ;
        end
      end
      default: begin
        state_nx   = SWEEP;
        sw_addr_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[sw_addr] <= '0;
    end else if (wr_acc && wr_in) begin
      for (int b = 0; b < NB; b++) begin
        if (byte_en[b]) begin
          mem[wr_idx][8*b +: 8] <= data_in[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      read_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      read_valid <= rd_acc;
      addr_err   <= (rd_acc && !rd_in) || (wr_acc && !wr_in);
      if (rd_acc) begin
        data_out <= rd_in ? rd_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_vec_mem.sv
// Self-checking bench for vec_mem: vector table plus scoreboard queue,
// with hand sequences for sweeps, clear and mid-sweep reset.
module tb_vec_mem;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int MS = 64;

`ifdef VEC_MEM_BYPASS_EN
  localparam logic [31:0] COL7 = 32'hDEADBEEF;
  localparam logic [31:0] COL3 = 32'h5522CC44;
`else
  localparam logic [31:0] COL7 = 32'h00000000;
  localparam logic [31:0] COL3 = 32'hAA22CC44;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          write_en;
  logic [AW-1:0] write_address;
  logic [3:0]    byte_en;
  logic [DW-1:0] data_in;
  logic          read_en;
  logic [AW-1:0] read_address;
  logic          clear_req;
  logic [DW-1:0] data_out;
  logic          read_valid;
  logic          busy;
  logic          addr_err;

  vec_mem #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MEM_SIZE  (MS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_en     (write_en),
    .write_address(write_address),
    .byte_en      (byte_en),
    .data_in      (data_in),
    .read_en      (read_en),
    .read_address (read_address),
    .clear_req    (clear_req),
    .data_out     (data_out),
    .read_valid   (read_valid),
    .busy         (busy),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [3:0]    be;
    logic [31:0]   din;
    logic          re;
    logic [AW-1:0] ra;
    logic [31:0]   ed;
    logic          ev;
    logic          ee;
  } vec_t;

  typedef struct {
    int          stamp;
    logic [31:0] d;
    logic        v;
    logic        e;
  } exp_t;

  vec_t tv [17];
  exp_t sbq [$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input bit ok,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa,
                       input logic [3:0] be, input logic [31:0] din,
                       input logic re, input logic [AW-1:0] ra,
                       input logic clr);
    @(negedge clk);
    write_en      = we;
    write_address = wa;
    byte_en       = be;
    data_in       = din;
    read_en       = re;
    read_address  = ra;
    clear_req     = clr;
  endtask

  task automatic idle();
    drive(1'b0, '0, 4'h0, 32'h0, 1'b0, '0, 1'b0);
  endtask

  task automatic expect_out(input logic [31:0] d, input logic v,
                            input logic e);
    exp_t x;
    x.stamp = cyc + 1;
    x.d     = d;
    x.v     = v;
    x.e     = e;
    sbq.push_back(x);
  endtask

  always begin
    exp_t x;
    @(posedge clk);
    #1;
    cyc++;
    if (sbq.size() > 0 && sbq[0].stamp == cyc) begin
      x = sbq.pop_front();
      chk("scoreboard {data,valid,err}",
          {data_out, read_valid, addr_err} == {x.d, x.v, x.e},
          64'({data_out, read_valid, addr_err}),
          64'({x.d, x.v, x.e}));
    end else if (read_valid || addr_err) begin
      chk("unexpected valid/err", 1'b0,
          64'({read_valid, addr_err}), 64'h0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    tv[0]  = '{1'b0, 7'd0,  4'h0, 32'h0,        1'b1, 7'd5,  32'h00000000, 1'b1, 1'b0};
    tv[1]  = '{1'b1, 7'd3,  4'hF, 32'hAABBCCDD, 1'b0, 7'd0,  32'h00000000, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 7'd3,  4'h5, 32'h11223344, 1'b0, 7'd0,  32'h00000000, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 7'd0,  4'h0, 32'h0,        1'b1, 7'd3,  32'hAA22CC44, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 7'd7,  4'hF, 32'hDEADBEEF, 1'b1, 7'd7,  COL7,         1'b1, 1'b0};
    tv[5]  = '{1'b0, 7'd0,  4'h0, 32'h0,        1'b1, 7'd7,  32'hDEADBEEF, 1'b1, 1'b0};
    tv[6]  = '{1'b1, 7'd0,  4'hF, 32'h12345678, 1'b0, 7'd0,  32'hDEADBEEF, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 7'd64, 4'hF, 32'hFFFFFFFF, 1'b0, 7'd0,  32'hDEADBEEF, 1'b0, 1'b1};
    tv[8]  = '{1'b0, 7'd0,  4'h0, 32'h0,        1'b1, 7'd0,  32'h12345678, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 7'd0,  4'h0, 32'h0,        1'b1, 7'd70, 32'h00000000, 1'b1, 1'b1};
    tv[10] = '{1'b0, 7'd0,  4'h0, 32'h0,        1'b0, 7'd0,  32'h00000000, 1'b0, 1'b0};
    tv[11] = '{1'b1, 7'd65, 4'hF, 32'hFFFFFFFF, 1'b1, 7'd3,  32'hAA22CC44, 1'b1, 1'b1};
    tv[12] = '{1'b1, 7'd3,  4'h0, 32'hFFFFFFFF, 1'b0, 7'd0,  32'hAA22CC44, 1'b0, 1'b0};
    tv[13] = '{1'b0, 7'd0,  4'h0, 32'h0,        1'b1, 7'd3,  32'hAA22CC44, 1'b1, 1'b0};
    tv[14] = '{1'b1, 7'd3,  4'h8, 32'h55667788, 1'b1, 7'd3,  COL3,         1'b1, 1'b0};
    tv[15] = '{1'b0, 7'd0,  4'h0, 32'h0,        1'b1, 7'd3,  32'h5522CC44, 1'b1, 1'b0};
    tv[16] = '{1'b1, 7'd64, 4'hF, 32'h0BADF00D, 1'b1, 7'd70, 32'h00000000, 1'b1, 1'b1};

    rst_n         = 1'b0;
    write_en      = 1'b0;
    write_address = '0;
    byte_en       = 4'h0;
    data_in       = 32'h0;
    read_en       = 1'b0;
    read_address  = '0;
    clear_req     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset data_out", data_out == 32'h0, 64'(data_out), 64'h0);
    chk("reset read_valid", read_valid == 1'b0, 64'(read_valid), 64'h0);
    chk("reset addr_err", addr_err == 1'b0, 64'(addr_err), 64'h0);
    chk("reset busy", busy == 1'b1, 64'(busy), 64'h1);

    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 200);
    chk("reset sweep length", n == 64, 64'(n), 64'd64);

    foreach (tv[i]) begin
      drive(tv[i].we, tv[i].wa, tv[i].be, tv[i].din,
            tv[i].re, tv[i].ra, 1'b0);
      expect_out(tv[i].ed, tv[i].ev, tv[i].ee);
    end
    idle();

    // Mid-sweep reset with a nonzero data_out in flight.
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1, 7'd0, 1'b0);
    expect_out(32'h12345678, 1'b1, 1'b0);
    drive(1'b0, '0, 4'h0, 32'h0, 1'b0, '0, 1'b1);
    idle();
    repeat (29) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midsweep rst data_out", data_out == 32'h0, 64'(data_out), 64'h0);
    chk("midsweep rst read_valid", read_valid == 1'b0, 64'(read_valid), 64'h0);
    chk("midsweep rst addr_err", addr_err == 1'b0, 64'(addr_err), 64'h0);
    chk("midsweep rst busy", busy == 1'b1, 64'(busy), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 200);
    chk("restart sweep length", n == 64, 64'(n), 64'd64);
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1, 7'd7, 1'b0);
    expect_out(32'h0, 1'b1, 1'b0);

    // Clear sweep with reads attempted while busy.
    for (int a = 0; a < 4; a++) begin
      drive(1'b1, AW'(a), 4'hF, 32'h01010101 * (a + 1), 1'b0, '0, 1'b0);
      expect_out(32'h0, 1'b0, 1'b0);
    end
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1, 7'd1, 1'b0);
    expect_out(32'h02020202, 1'b1, 1'b0);
    drive(1'b0, '0, 4'h0, 32'h0, 1'b0, '0, 1'b1);
    @(posedge clk);
    #1;
    chk("clear busy", busy == 1'b1, 64'(busy), 64'h1);
    n = 0;
    do begin
      drive(1'b1, 7'd2, 4'hF, 32'hFFFFFFFF, 1'b1, 7'd2, 1'b0);
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 200);
    chk("clear sweep length", n == 64, 64'(n), 64'd64);
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1, 7'd2, 1'b0);
    expect_out(32'h0, 1'b1, 1'b0);
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1, 7'd1, 1'b0);
    expect_out(32'h0, 1'b1, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", sbq.size() == 0, 64'(sbq.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vec_mem.md
VEC_MEM -- requirements
Module: vec_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, address port width.
REQ-003 SHALL have parameter MEM_SIZE, default 64, number of words; must satisfy MEM_SIZE <= 2^ADDR_WIDTH.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port write_en  input  1  write request.
REQ-007 SHALL have port write_address  input  ADDR_WIDTH  write word address.
REQ-008 SHALL have port byte_en  input  DATA_WIDTH/8  per-byte write mask; bit i covers data_in[8i+7:8i].
REQ-009 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-010 SHALL have port read_en  input  1  read request.
REQ-011 SHALL have port read_address  input  ADDR_WIDTH  read word address.
REQ-012 SHALL have port clear_req  input  1  single-cycle request to zero the whole array.
REQ-013 SHALL have port data_out  output  DATA_WIDTH  registered read data.
REQ-014 SHALL have port read_valid  output  1  one-cycle pulse qualifying data_out.
REQ-015 SHALL have port busy  output  1  high while a clear sweep is in progress.
REQ-016 SHALL have port addr_err  output  1  one-cycle pulse on an accepted access with address >= MEM_SIZE.

Function
REQ-017 SHALL implement a three-state controller: SWEEP, IDLE, and SWEEP_REQ (a sweep started by clear_req); busy = 1 in SWEEP and SWEEP_REQ.
REQ-018 SHALL, in either sweep state, write zero to one word per cycle starting at address 0, reaching IDLE the cycle after word MEM_SIZE-1 is written, so a sweep takes exactly MEM_SIZE cycles.
REQ-019 SHALL ignore write_en, read_en and clear_req while busy = 1; no read_valid, no addr_err, no array change other than the sweep.
REQ-020 SHALL, in IDLE with clear_req = 1, enter SWEEP_REQ next cycle; a same-cycle write or read is still performed before the sweep starts.
REQ-021 SHALL, in IDLE with write_en = 1 and address < MEM_SIZE, update only the bytes whose byte_en bit is 1; byte_en = 0 leaves the word unchanged.
REQ-022 SHALL, in IDLE with read_en = 1, present the word on data_out and pulse read_valid exactly one cycle later (latency 1).
REQ-023 SHALL hold data_out unchanged when no read completes.
REQ-024 SHALL, for an out-of-range write, leave the array unchanged and pulse addr_err one cycle later.
REQ-025 SHALL, for an out-of-range read, return data_out = 0 with read_valid = 1 and addr_err = 1 one cycle later.
REQ-026 SHALL, when an in-range read and an out-of-range write occur in the same cycle, assert addr_err once.
REQ-027 SHALL, for a same-cycle read and write to the same address, return per the Configuration section.

Reset
REQ-028 SHALL, while rst_n = 0, force data_out = 0, read_valid = 0, addr_err = 0, busy = 1, state = SWEEP, sweep address = 0, independent of clk.
REQ-029 SHALL start the SWEEP on the first rising edge after rst_n deasserts, so all words read as 0 once busy falls.
REQ-030 SHALL, if reset asserts mid-sweep or mid-access, abandon the operation and restart the full sweep from address 0.

Configuration
REQ-031 SHALL, with macro VEC_MEM_BYPASS_EN defined, forward on a same-address read/write collision: each byte of data_out is data_in where byte_en = 1, else the old contents.
REQ-032 SHALL, without VEC_MEM_BYPASS_EN, return the old (pre-write) contents on such a collision.

Verification
REQ-033 SHALL verify the reset sweep: release rst_n -> busy = 1 for exactly 64 cycles; then a read of address 5 -> data_out = 0x00000000, read_valid one cycle later.
REQ-034 SHALL verify the byte mask: write 0xAABBCCDD to address 3 with byte_en = 1111, then write 0x11223344 with byte_en = 0101 -> a read of address 3 returns 0xAA22CC44.
REQ-035 SHALL verify collision: address 7 holds 0x0, write 0xDEADBEEF (byte_en = 1111) and read address 7 in the same cycle -> data_out = 0xDEADBEEF with bypass, 0x00000000 without.
REQ-036 SHALL verify range errors: write to address 64 -> addr_err pulses and the array is unchanged; read address 70 -> data_out = 0, read_valid = 1, addr_err = 1.
REQ-037 SHALL verify clear_req: fill addresses 0-3, pulse clear_req, drive a read during busy -> no read_valid; after 64 cycles busy = 0 and address 2 reads 0.
REQ-038 SHALL verify reset mid-sweep: assert rst_n low at sweep cycle 30 -> outputs take their reset values immediately; after release, busy stays high for a full 64 cycles.
